// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter whose storage is a bank of T cells (q <= q ^ t_vec).
// Optional TCNT_SAT_EN: continuous mode saturates at the terminal value instead of wrapping.
module tff_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             done
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("tff_mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q;
    logic             at_term;

    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        at_term = up ? (q_q == MAX_CNT) : (q_q == '0);
        tc      = (state_q == RUN) & en & ~load & at_term & ~rst;

        if (load) begin
            // Load wins over counting but still lets start leave IDLE/DONE.
            q_d = (din > MAX_CNT) ? MAX_CNT : din;
            if (start && state_q != RUN) begin
                state_d = RUN;
            end
        end else if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
            end
        end else if (en) begin
            if (at_term) begin
                if (oneshot) begin
                    state_d = DONE;
                end else begin
`ifdef TCNT_SAT_EN
                    q_d = q_q;
`else
                    q_d = up ? '0 : MAX_CNT;
`endif
                end
            end else begin
                q_d = up ? (q_q + 1'b1) : (q_q - 1'b1);
            end
        end

        // The cells only ever see toggles; the next count is reached by flipping differing bits.
        t_vec = rst ? '0 : (q_q ^ q_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_q ^ t_vec;
            done_q  <= (state_d == DONE);
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign done = done_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter (WIDTH=4, MODULUS=10): a reference model pushes expected
// q/done into a scoreboard queue as stimulus is driven; each test pops and compares.
module tb_tff_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, en = 1'b0, up = 1'b1, oneshot = 1'b0, load = 1'b0;
    logic [3:0] din = 4'd0;
    logic [3:0] t_vec, q, qbar;
    logic       tc, done;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .up(up), .oneshot(oneshot),
        .load(load), .din(din), .t_vec(t_vec), .q(q), .qbar(qbar), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 IDLE, 1 RUN, 2 DONE
    logic [3:0] m_q = 4'd0;
    int         m_st = 0;
    logic [3:0] p_q;
    int         p_st;
    logic [3:0] exp_q_fifo[$];
    logic       exp_done_fifo[$];
    logic       exp_tc, obs_tc;
    logic [3:0] exp_tvec, obs_tvec;
    logic [3:0] want_q;
    logic       want_done;

    typedef struct packed {
        logic       s, e, u, o, l;
        logic [3:0] d;
        logic [3:0] wq;
        logic       wd;
    } vec_t;

    // qbar must always be the complement of q
    always @(negedge clk) begin
        n_tests++;
        if (qbar !== ~q) begin
            n_fail++;
            $display("FAIL qbar_inv t=%0t qbar=%h q=%h", $time, qbar, q);
        end
    end

    // Called just after a rising edge: drive inputs, run model, sample comb outputs, clock.
    task automatic step(input logic s, input logic e, input logic u, input logic o,
                        input logic l, input logic [3:0] d);
        logic term;
        start = s; en = e; up = u; oneshot = o; load = l; din = d;
        term   = u ? (m_q == 4'd9) : (m_q == 4'd0);
        exp_tc = (m_st == 1) && e && !l && term;
        p_q  = m_q;
        p_st = m_st;
        if (l) begin
            p_q = (d > 4'd9) ? 4'd9 : d;
            if (s && m_st != 1) p_st = 1;
        end else if (m_st != 1) begin
            if (s) p_st = 1;
        end else if (e) begin
            if (term) begin
                if (o) p_st = 2;
                else begin
`ifdef TCNT_SAT_EN
                    p_q = m_q;
`else
                    p_q = u ? 4'd0 : 4'd9;
`endif
                end
            end else begin
                p_q = u ? m_q + 4'd1 : m_q - 4'd1;
            end
        end
        exp_tvec = m_q ^ p_q;
        exp_q_fifo.push_back(p_q);
        exp_done_fifo.push_back(p_st == 2);
        #1;
        obs_tc   = tc;
        obs_tvec = t_vec;
        @(posedge clk);
        #1;
        m_q   = p_q;
        m_st  = p_st;
        start = 1'b0;
        load  = 1'b0;
    endtask

    task automatic pop_expect();
        want_q    = exp_q_fifo.pop_front();
        want_done = exp_done_fifo.pop_front();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_tests++;
        if ({q, qbar, done, tc, t_vec} !== {4'h0, 4'hF, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_vals q=%h qbar=%h done=%b tc=%b tvec=%h want 0 F 0 0 0",
                     q, qbar, done, tc, t_vec);
        end
        rst = 1'b0; start = 1'b0;
        m_q = 4'd0; m_st = 0;
        exp_q_fifo.delete(); exp_done_fifo.delete();
        @(posedge clk); #1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        pop_expect();
        n_tests++;
        if (q !== want_q || q !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_no_count q=%h want %h", q, want_q);
        end
    endtask

    task automatic test_count_up();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        pop_expect();
        n_tests++;
        if ({done, q} !== {want_done, want_q} || q !== 4'd0) begin
            n_fail++;
            $display("FAIL start_edge q=%h want %h", q, want_q);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            pop_expect();
            n_tests++;
            if ({done, q} !== {want_done, want_q} || q !== 4'((i + 1) % 10)) begin
                n_fail++;
                $display("FAIL up_seq%0d q=%h done=%b want q=%h done=%b",
                         i, q, done, want_q, want_done);
            end
            n_tests++;
            if (obs_tc !== exp_tc || obs_tc !== (i == 9)) begin
                n_fail++;
                $display("FAIL up_tc%0d tc=%b want %b", i, obs_tc, exp_tc);
            end
            if (i == 9) begin
                n_tests++;
                if (obs_tvec !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL wrap_tvec t_vec=%b want 1001", obs_tvec);
                end
            end
        end
    endtask

    task automatic test_down_load();
        vec_t tbl[5];
        tbl = '{'{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'd0, 1'b0},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'd9, 1'b0},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 4'd9, 1'b0},
                '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'd8, 1'b0},
                '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 4'd3, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].s, tbl[i].e, tbl[i].u, tbl[i].o, tbl[i].l, tbl[i].d);
            pop_expect();
            n_tests++;
            if ({done, q} !== {want_done, want_q} || {done, q} !== {tbl[i].wd, tbl[i].wq}) begin
                n_fail++;
                $display("FAIL download%0d q=%h done=%b want q=%h done=%b",
                         i, q, done, tbl[i].wq, tbl[i].wd);
            end
            n_tests++;
            if (obs_tvec !== exp_tvec) begin
                n_fail++;
                $display("FAIL download_tvec%0d t_vec=%b want %b", i, obs_tvec, exp_tvec);
            end
        end
    endtask

    task automatic test_oneshot();
        vec_t tbl[7];
        tbl = '{'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 4'd7, 1'b0},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd8, 1'b0},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd9, 1'b0},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd9, 1'b1},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd9, 1'b1},
                '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'd9, 1'b0},
                '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0}};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].s, tbl[i].e, tbl[i].u, tbl[i].o, tbl[i].l, tbl[i].d);
            pop_expect();
            n_tests++;
            if ({done, q} !== {want_done, want_q} || {done, q} !== {tbl[i].wd, tbl[i].wq}) begin
                n_fail++;
                $display("FAIL oneshot%0d q=%h done=%b want q=%h done=%b",
                         i, q, done, tbl[i].wq, tbl[i].wd);
            end
            n_tests++;
            if (obs_tc !== exp_tc) begin
                n_fail++;
                $display("FAIL oneshot_tc%0d tc=%b want %b", i, obs_tc, exp_tc);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        pop_expect(); pop_expect(); pop_expect(); pop_expect(); pop_expect();
        n_tests++;
        if (q !== want_q || q !== 4'd5) begin
            n_fail++;
            $display("FAIL pre_rst q=%h want 5", q);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({q, done, tc} !== {4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst q=%h done=%b tc=%b want 0 0 0", q, done, tc);
        end
        #1;
        rst = 1'b0;
        m_q = 4'd0; m_st = 0;
        @(posedge clk); #1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        pop_expect();
        n_tests++;
        if (q !== want_q || q !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_idle q=%h want 0", q);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        pop_expect();
        pop_expect();
        n_tests++;
        if (q !== want_q || q !== 4'd5) begin
            n_fail++;
            $display("FAIL start_load q=%h want 5", q);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        pop_expect();
        n_tests++;
        if (q !== want_q || q !== 4'd6) begin
            n_fail++;
            $display("FAIL start_in_run q=%h want 6", q);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] wq[6];
        logic       wtc[6];
`ifdef TCNT_SAT_EN
        wq  = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
        wtc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        wq  = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd1};
        wtc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i != 0), (i != 5), 1'b0, (i == 0), 4'd8);
            pop_expect();
            n_tests++;
            if (q !== want_q || q !== wq[i]) begin
                n_fail++;
                $display("FAIL sat%0d q=%h want %h", i, q, wq[i]);
            end
            n_tests++;
            if (obs_tc !== exp_tc || obs_tc !== wtc[i]) begin
                n_fail++;
                $display("FAIL sat_tc%0d tc=%b want %b", i, obs_tc, wtc[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_down_load();
        test_oneshot();
        test_async_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
